outbuf_drain: RTL
=================

// Module: outbuf_drain
// PURPOSE
//  Output-side buffer for the PE array: the counterpart of the input skew buffers.
//  Captures result words from one PE-array output lane and discards the leading SKIP
//  fill words that the array's skew produces. Counts one frame of FRAMELEN results
//  and presents them to the host/readout through a first-word-fall-through
//  valid/ready port. One instance per array output lane.
// PARAMETERS
//  WORDLEN   8    result word width
//  BUFSIZE   16   FIFO depth in words; legal range 2..32 (5-bit pointers)
//  SKIP      0    leading pe_valid beats discarded after start; legal range 0..31
//  FRAMELEN  8    result beats captured per frame after skip; legal range 1..255
// PORTS
//  clk         in   1        clock, rising edge
//  rstn        in   1        asynchronous active-low reset
//  start       in   1        1-cycle pulse: begin a frame
//  pe_valid    in   1        PE lane presents a word this cycle
//  pe_din      in   WORDLEN  PE lane result word
//  dout        out  WORDLEN  head word; 0 when empty
//  dout_valid  out  1        = !empty
//  dout_ready  in   1        consumer pops head when dout_valid & dout_ready
//  full        out  1        count == BUFSIZE
//  empty       out  1        count == 0
//  count       out  6        words held, 0..BUFSIZE
//  overflow    out  1        sticky: a capture beat was dropped because the FIFO was full
//  busy        out  1        FSM not in DR_IDLE
//  done        out  1        1-cycle pulse, registered, the cycle after the last capture beat
// BEHAVIOUR
//  Reset (async, rstn=0): FSM=DR_IDLE; pointers, count, skip counter and beat counter = 0.
//   Outputs: dout=0, dout_valid=0, full=0, empty=1, count=0, overflow=0, busy=0, done=0.
//   Storage array is not reset; the dout masking hides it.
//   Reset mid-frame aborts the frame; FIFO contents are lost.
//  FSM:
//   DR_IDLE:    start goes to DR_SKIP if SKIP>0, else to DR_CAPTURE.
//               start also clears overflow and loads the counters.
//               pe_valid is ignored in this state.
//   DR_SKIP:    each pe_valid beat decrements the skip counter; the word is discarded.
//               The SKIP-th beat goes to DR_CAPTURE.
//   DR_CAPTURE: each pe_valid beat increments the beat counter.
//               The word is pushed if (!full || pop this cycle); otherwise it is dropped
//               and overflow is set.
//               The FRAMELEN-th beat goes to DR_IDLE; done=1 on the following cycle.
//   start while busy=1 is ignored.
//  FIFO (circular, head=oldest, tail=next free):
//   Pointers wrap from BUFSIZE-1 to 0.
//   Push writes mem[tail]; the word is visible on dout the next cycle when the FIFO was empty.
//   dout = empty ? 0 : mem[head], combinational from the registered head.
//   Pop occurs when dout_valid & dout_ready; dout_ready while empty has no effect.
//   Push and pop in the same cycle: both happen and count is unchanged, including when full.
//   Push with no pop: count+1. Pop with no push: count-1.
//   full, empty and count derive from the registered count.
//  Latency: pe_din to dout/dout_valid = 1 cycle when the FIFO is empty.
//  Frame boundaries are not marked in the FIFO; the consumer uses done and count.
// STRUCTURE
//  systola_pkg holds:
//   typedef enum logic[1:0] {DR_IDLE, DR_SKIP, DR_CAPTURE} drain_state_t;
//   localparam PTR_W=5.
//  Sub-module outbuf_fifo_core: storage, head/tail, count, push/pop with full/empty.
//  outbuf_drain holds the FSM, the skip and beat counters, overflow, done and the push gating.
// TESTING
//  1 Reset values: assert rstn=0 mid-frame -> all outputs at reset values within the same
//    cycle; busy=0; empty=1.
//  2 SKIP=2, FRAMELEN=4: start, then pe_valid beats 0xA0..0xA5 -> FIFO holds A2,A3,A4,A5;
//    done pulses once; busy=0.
//  3 BUFSIZE=4, FRAMELEN=6, dout_ready=0: 6 beats 1..6 -> count=4, full=1, overflow=1,
//    FIFO holds 1..4; next start clears overflow.
//  4 Full with simultaneous pop: FIFO full, push 9 with dout_ready=1 -> old head leaves,
//    9 enters, count stays BUFSIZE, overflow stays 0.
//  5 Wrap-around: BUFSIZE=4, 10 frames of 3 words each with continuous dout_ready=1 ->
//    output sequence matches input exactly; count never exceeds 1.
//  6 Ignored events: pe_valid while idle, start while busy, dout_ready while empty ->
//    no state change; dout=0.

Source files
------------

// File: rtl/systola_pkg.sv
// Shared types and helpers for the systola output-side drain buffers.
// Holds the drain FSM encoding and the circular-pointer arithmetic.
package systola_pkg;

    typedef enum logic [1:0] {DR_IDLE, DR_SKIP, DR_CAPTURE} drain_state_t;

    localparam int PTR_W = 5;

    // Advance a circular pointer, wrapping from depth-1 back to 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p, input int depth);
        return (p == PTR_W'(depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/outbuf_fifo_core.sv
// Circular first-word-fall-through FIFO: storage, head/tail pointers and the word count.
// The caller gates push so it only arrives when there is room or a pop in the same cycle.
module outbuf_fifo_core
    import systola_pkg::*;
#(
    parameter int WORDLEN = 8,
    parameter int BUFSIZE = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push,
    input  logic [WORDLEN-1:0] din,
    input  logic               dout_ready,
    output logic               pop,
    output logic [WORDLEN-1:0] dout,
    output logic               full,
    output logic               empty,
    output logic [5:0]         count
);

    // Sized to the full pointer range so a 5-bit pointer indexes it without truncation.
    logic [WORDLEN-1:0] mem [2**PTR_W];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [5:0]         cnt;

    assign empty = (cnt == 6'd0);
    assign full  = (cnt == 6'(BUFSIZE));
    assign count = cnt;
    assign pop   = dout_ready & ~empty;
    assign dout  = empty ? '0 : mem[head];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= ptr_inc(tail, BUFSIZE);
            end
            if (pop) begin
                head <= ptr_inc(head, BUFSIZE);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 6'd1;
                2'b01:   cnt <= cnt - 6'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/outbuf_drain.sv
// Output-lane drain buffer: drops the leading SKIP skew-fill beats, captures FRAMELEN
// results per frame and presents them through a first-word-fall-through FIFO.
module outbuf_drain
    import systola_pkg::*;
#(
    parameter int WORDLEN  = 8,
    parameter int BUFSIZE  = 16,
    parameter int SKIP     = 0,
    parameter int FRAMELEN = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               pe_valid,
    input  logic [WORDLEN-1:0] pe_din,
    output logic [WORDLEN-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               full,
    output logic               empty,
    output logic [5:0]         count,
    output logic               overflow,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    // Readout handshake: a word transfers on every cycle where dout_valid and dout_ready
    // are both high; dout_valid never depends on dout_ready, and dout_ready while empty
    // does nothing.

    drain_state_t state;
    drain_state_t state_nxt;
    logic [4:0]   skip_cnt;
    logic [7:0]   beat_cnt;
    logic         load;
    logic         skip_beat;
    logic         capture;
    logic         frame_end;
    logic         push;
    logic         pop;
    logic         drop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= DR_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        skip_beat = 1'b0;
        capture   = 1'b0;
        frame_end = 1'b0;
        case (state)
            DR_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = (SKIP > 0) ? DR_SKIP : DR_CAPTURE;
                end
            end
            DR_SKIP: begin
                if (pe_valid) begin
                    skip_beat = 1'b1;
                    if (skip_cnt == 5'd1) begin
                        state_nxt = DR_CAPTURE;
                    end
                end
            end
            DR_CAPTURE: begin
                if (pe_valid) begin
                    capture = 1'b1;
                    if (beat_cnt == 8'(FRAMELEN - 1)) begin
                        frame_end = 1'b1;
                        state_nxt = DR_IDLE;
                    end
                end
            end
            default: state_nxt = DR_IDLE;
        endcase
    end

    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign push = capture & (~full | pop);
    assign drop = capture & ~push;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skip_cnt <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= frame_end;
            if (load) begin
                skip_cnt <= 5'(SKIP);
                beat_cnt <= '0;
                overflow <= 1'b0;
            end else begin
                if (skip_beat) begin
                    skip_cnt <= skip_cnt - 5'd1;
                end
                if (capture) begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
            end
        end
    end

    outbuf_fifo_core #(
        .WORDLEN (WORDLEN),
        .BUFSIZE (BUFSIZE)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (push),
        .din        (pe_din),
        .dout_ready (dout_ready),
        .pop        (pop),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    assign dout_valid = ~empty;
    assign busy       = (state != DR_IDLE);
    assign dbg_state  = state;

endmodule
